// File: rtl/module_pulso_nivel_pkg.sv
// Shared types and helpers for the pulse-to-level driver.
//   state_t    : controller state encoding (IDLE, HOLD, GUARD)
//   cnt_width  : width of the shared hold/guard down-counter
package pkg_pulso_nivel;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    GUARD = 2'd2
  } state_t;

  // Wide enough to hold max(hold, guard) - 1. The floor of 2 keeps the width at 1 or more.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned guard);
    int unsigned m;
    m = (hold > guard) ? hold : guard;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/module_pulso_nivel_contador_carga.sv
// Loadable down-counter used for both the hold and guard intervals.
//   clk_i, rst_n_i : clock and asynchronous active-low reset (reset clears the count to 0)
//   load_i         : load load_val_i (has priority over decrement)
//   load_val_i     : value to load
//   dec_i          : decrement enable; ignored at zero so the count never wraps
//   zero_o         : count is zero
module module_contador_carga #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/module_pulso_nivel.sv
// Pulse-to-level driver: a one-cycle trigger drives nivel_o high for HOLD_CYCLES cycles,
// followed by a GUARD_CYCLES lockout during which triggers are ignored.
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   pulso_i  : one-cycle trigger
//   cancel_i : abort the current hold (wins over pulso_i)
//   nivel_o  : driven level, high in HOLD
//   busy_o   : high in HOLD or GUARD
//   fin_o    : one-cycle pulse when a hold ends by timeout
// All outputs come straight from flops; none depends combinationally on an input.
module module_pulso_nivel
  import pkg_pulso_nivel::*;
#(
  parameter int unsigned HOLD_CYCLES  = 10_000_000,
  parameter int unsigned GUARD_CYCLES = 1_000_000,
  parameter bit          RETRIGGER    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pulso_i,
  input  logic cancel_i,
  output logic nivel_o,
  output logic busy_o,
  output logic fin_o
);

  localparam int unsigned W = cnt_width(HOLD_CYCLES, GUARD_CYCLES);
  localparam logic [W-1:0] HoldLoad  = W'(HOLD_CYCLES - 1);
  localparam logic [W-1:0] GuardLoad = W'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
  localparam bit NoGuard = (GUARD_CYCLES == 0);

  state_t         state_d, state_q;
  logic           load, dec, zero;
  logic [W-1:0]   load_val;
  logic           fin_d;
  logic           nivel_q, busy_q, fin_q;

  module_contador_carga #(
    .Width (W)
  ) u_contador (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (load),
    .load_val_i (load_val),
    .dec_i      (dec),
    .zero_o     (zero)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    dec      = 1'b0;
    fin_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pulso_i && !cancel_i) begin
          state_d  = HOLD;
          load     = 1'b1;
          load_val = HoldLoad;
        end
      end
      HOLD: begin
        if (cancel_i) begin
          state_d  = NoGuard ? IDLE : GUARD;
          load     = 1'b1;
          load_val = GuardLoad;
        end else if (pulso_i && RETRIGGER) begin
          load     = 1'b1;
          load_val = HoldLoad;
        end else if (zero) begin
          state_d  = NoGuard ? IDLE : GUARD;
          load     = 1'b1;
          load_val = GuardLoad;
          fin_d    = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      GUARD: begin
        if (zero) begin
          state_d = IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      nivel_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nivel_q <= (state_d == HOLD);
      busy_q  <= (state_d != IDLE);
      fin_q   <= fin_d;
    end
  end

  assign nivel_o = nivel_q;
  assign busy_o  = busy_q;
  assign fin_o   = fin_q;

endmodule
